// File: rtl/alu_pkg.sv
// Shared ALU package: operand/control widths, ALU control codes and the
// MIPS opcode/funct values decoded by the issue block (and used by the ALU).
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 4;

   // ALU control codes
   localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_AND = 4'b0100;
   localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0101;
   localparam logic [CTRL_W-1:0] ALU_NOR = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_SLL = 4'b1000;
   localparam logic [CTRL_W-1:0] ALU_SRA = 4'b1001;
   localparam logic [CTRL_W-1:0] ALU_SRL = 4'b1010;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;

   // One decoded ALU operation as carried through the issue buffer
   typedef struct packed {
      logic [CTRL_W-1:0] control;
      logic [DATA_W-1:0] first;
      logic [DATA_W-1:0] second;
      logic              illegal;
   } alu_op_t;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational MIPS opcode/funct decoder producing the ALU control
// code and both operands. Unknown encodings decode to ADD with zero operands
// and the illegal flag set.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [4:0]        shamt,
   input  logic [15:0]       imm16,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output alu_op_t           op
);

   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_zext;

   assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
   assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};

   // Decode table; defaults describe the illegal-op result
   always_comb begin
      op.control = ALU_ADD;
      op.first   = '0;
      op.second  = '0;
      op.illegal = 1'b0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD, FN_ADDU: begin op.control = ALU_ADD; op.first = rs_val; op.second = rt_val; end
            FN_SUB, FN_SUBU: begin op.control = ALU_SUB; op.first = rs_val; op.second = rt_val; end
            FN_AND:          begin op.control = ALU_AND; op.first = rs_val; op.second = rt_val; end
            FN_OR:           begin op.control = ALU_OR;  op.first = rs_val; op.second = rt_val; end
            FN_XOR:          begin op.control = ALU_XOR; op.first = rs_val; op.second = rt_val; end
            FN_NOR:          begin op.control = ALU_NOR; op.first = rs_val; op.second = rt_val; end
            FN_SLL:  begin op.control = ALU_SLL; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, shamt}; end
            FN_SRL:  begin op.control = ALU_SRL; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, shamt}; end
            FN_SRA:  begin op.control = ALU_SRA; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, shamt}; end
            FN_SLLV: begin op.control = ALU_SLL; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, rs_val[4:0]}; end
            FN_SRLV: begin op.control = ALU_SRL; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, rs_val[4:0]}; end
            FN_SRAV: begin op.control = ALU_SRA; op.first = rt_val; op.second = {{(DATA_W-5){1'b0}}, rs_val[4:0]}; end
            default: op.illegal = 1'b1;
         endcase
      end else begin
         case (opcode)
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW:
                            begin op.control = ALU_ADD; op.first = rs_val; op.second = imm_sext; end
            OP_ANDI:        begin op.control = ALU_AND; op.first = rs_val; op.second = imm_zext; end
            OP_ORI:         begin op.control = ALU_OR;  op.first = rs_val; op.second = imm_zext; end
            OP_XORI:        begin op.control = ALU_XOR; op.first = rs_val; op.second = imm_zext; end
            OP_BEQ, OP_BNE: begin op.control = ALU_SUB; op.first = rs_val; op.second = rt_val; end
            default:        op.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_issue.sv
// ALU op issue stage: decodes the ID-stage instruction and holds the result
// in a valid/ready register until EX accepts it. Latency is one cycle.
// Build option ALU_ISSUE_SKID_EN: adds a skid register so in_ready is a flop
// and does not depend combinationally on out_ready.
module alu_op_issue #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [4:0]        shamt,
   input  logic [15:0]       imm16,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_first,
   output logic [DATA_W-1:0] alu_second,
   output logic [CTRL_W-1:0] alu_control,
   output logic              illegal
);

   import alu_pkg::*;

   alu_op_t dec_p0;
   alu_op_t main_op_p1;
   logic    vld_p1;
   logic    accept;
   logic    main_free;

   alu_op_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .shamt  (shamt),
      .imm16  (imm16),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .op     (dec_p0)
   );

   assign accept    = in_valid && in_ready;
   assign main_free = !vld_p1 || out_ready;

`ifdef ALU_ISSUE_SKID_EN
   alu_op_t skid_op_p1;
   logic    skid_vld_p1;
   logic    rdy_p1;

   assign in_ready = rdy_p1;

   // Valid bits and registered ready: main refills from skid first, skid
   // only captures when main is stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b0;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b1;
      end else if (main_free) begin
         vld_p1      <= skid_vld_p1 || accept;
         skid_vld_p1 <= 1'b0;
         rdy_p1      <= 1'b1;
      end else if (accept) begin
         skid_vld_p1 <= 1'b1;
         rdy_p1      <= 1'b0;
      end
   end

   // Payload registers; contents only meaningful under their valid bits
   always_ff @(posedge clk) begin
      if (main_free)
         main_op_p1 <= skid_vld_p1 ? skid_op_p1 : dec_p0;
      if (!main_free && accept)
         skid_op_p1 <= dec_p0;
   end
`else
   assign in_ready = rst_n && main_free;

   // Valid bit of the single output register
   always_ff @(posedge clk) begin
      if (!rst_n)
         vld_p1 <= 1'b0;
      else if (flush)
         vld_p1 <= 1'b0;
      else if (main_free)
         vld_p1 <= accept;
   end

   // Payload register; held while the output is stalled
   always_ff @(posedge clk) begin
      if (main_free)
         main_op_p1 <= dec_p0;
   end
`endif

   // Output stage: payload forced to zero whenever no op is presented
   assign out_valid   = vld_p1;
   assign alu_first   = vld_p1 ? main_op_p1.first   : '0;
   assign alu_second  = vld_p1 ? main_op_p1.second  : '0;
   assign alu_control = vld_p1 ? main_op_p1.control : '0;
   assign illegal     = vld_p1 ? main_op_p1.illegal : 1'b0;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue (either build of
// ALU_ISSUE_SKID_EN). Inputs change on the falling edge; outputs are sampled
// 1 time unit after the falling edge.
module tb_alu_op_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_first;
   logic [31:0] alu_second;
   logic [3:0]  alu_control;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

`ifdef ALU_ISSUE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_op_issue dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .funct       (funct),
      .shamt       (shamt),
      .imm16       (imm16),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_first   (alu_first),
      .alu_second  (alu_second),
      .alu_control (alu_control),
      .illegal     (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Settle, record handshakes seen before the rising edge, advance one cycle
   task automatic tick(output bit in_fire, output bit out_fire, output logic [31:0] first_seen);
      #1;
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
      first_seen = alu_first;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
      opcode = op; funct = fn; shamt = sh; imm16 = imm; rs_val = rs; rt_val = rt;
   endtask

   // Present one op with out_ready=1 for one cycle; outputs then hold its result
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
      bit fi, fo;
      logic [31:0] fs;
      set_op(op, fn, sh, imm, rs, rt);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick(fi, fo, fs);
      in_valid  = 1'b0;
      #1;
   endtask

   initial begin
      bit fi, fo;
      logic [31:0] fs;
      logic [31:0] vals [3];
      logic [31:0] got [$];
      int idx;

      vals[0] = 32'd11; vals[1] = 32'd22; vals[2] = 32'd33;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_op(6'h00, 6'h20, 5'd0, 16'h0, 32'h0, 32'h0);

      // Reset state
      @(negedge clk);
      repeat (3) tick(fi, fo, fs);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_first", alu_first, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;
      tick(fi, fo, fs);
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);

      // add
      issue(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_ctrl", 32'(alu_control), 32'h0);
      chk("add_first", alu_first, 32'd5);
      chk("add_second", alu_second, 32'd7);

      // addi (sign-extended) and ori (zero-extended)
      issue(6'h08, 6'h00, 5'd0, 16'hFFFE, 32'd10, 32'd0);
      chk("addi_ctrl", 32'(alu_control), 32'h0);
      chk("addi_first", alu_first, 32'd10);
      chk("addi_second", alu_second, 32'hFFFF_FFFE);
      issue(6'h0D, 6'h00, 5'd0, 16'hFFFE, 32'd10, 32'd0);
      chk("ori_ctrl", 32'(alu_control), 32'h5);
      chk("ori_second", alu_second, 32'h0000_FFFE);

      // sub and nor
      issue(6'h00, 6'h22, 5'd0, 16'h0, 32'd9, 32'd4);
      chk("sub_ctrl", 32'(alu_control), 32'h2);
      issue(6'h00, 6'h27, 5'd0, 16'h0, 32'd9, 32'd4);
      chk("nor_ctrl", 32'(alu_control), 32'h6);

      // sra / srav
      issue(6'h00, 6'h03, 5'd4, 16'h0, 32'd0, 32'h8000_0000);
      chk("sra_ctrl", 32'(alu_control), 32'h9);
      chk("sra_first", alu_first, 32'h8000_0000);
      chk("sra_second", alu_second, 32'd4);
      issue(6'h00, 6'h07, 5'd0, 16'h0, 32'h23, 32'h8000_0000);
      chk("srav_ctrl", 32'(alu_control), 32'h9);
      chk("srav_second", alu_second, 32'd3);

      // beq uses rs/rt with SUB
      issue(6'h04, 6'h00, 5'd0, 16'h1234, 32'd3, 32'd8);
      chk("beq_ctrl", 32'(alu_control), 32'h2);
      chk("beq_second", alu_second, 32'd8);

      // illegal opcode still flows through
      issue(6'h3F, 6'h20, 5'd3, 16'hFFFF, 32'd5, 32'd7);
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_ctrl", 32'(alu_control), 32'h0);
      chk("ill_first", alu_first, 32'd0);
      chk("ill_second", alu_second, 32'd0);
      tick(fi, fo, fs);
      #1;
      chk("idle_valid", 32'(out_valid), 32'd0);

      // Backpressure: 3 stalled cycles while 3 ops are offered
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 3; c++) begin
         in_valid = (idx < 3);
         set_op(6'h00, 6'h20, 5'd0, 16'h0, vals[idx % 3], 32'd0);
         tick(fi, fo, fs);
         if (fi) begin
            idx++;
            #1;
            if (idx == 1) chk("bp_rdy_after1", 32'(in_ready), SKID ? 32'd1 : 32'd0);
            if (idx == 2) chk("bp_rdy_after2", 32'(in_ready), 32'd0);
         end
      end
      chk("bp_accepted", 32'(idx), SKID ? 32'd2 : 32'd1);
      chk("bp_held_first", alu_first, 32'd11);
      out_ready = 1'b1;
      for (int c = 0; c < 12 && got.size() < 3; c++) begin
         in_valid = (idx < 3);
         set_op(6'h00, 6'h20, 5'd0, 16'h0, vals[idx % 3], 32'd0);
         tick(fi, fo, fs);
         if (fo) got.push_back(fs);
         if (fi) idx++;
      end
      in_valid = 1'b0;
      chk("bp_count", 32'(got.size()), 32'd3);
      for (int k = 0; k < 3; k++)
         chk($sformatf("bp_order%0d", k), (k < got.size()) ? got[k] : 32'hDEAD_BEEF, vals[k]);
      #1;
      chk("bp_drained", 32'(out_valid), 32'd0);

      // flush with buffered ops and a same-cycle input
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4 && idx < 2; c++) begin
         in_valid = 1'b1;
         set_op(6'h00, 6'h20, 5'd0, 16'h0, (idx == 0) ? 32'd44 : 32'd55, 32'd0);
         tick(fi, fo, fs);
         if (fi) idx++;
         if (!SKID && idx == 1) break;
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      set_op(6'h00, 6'h20, 5'd0, 16'h0, 32'd66, 32'd0);
      tick(fi, fo, fs);
      flush = 1'b0;
      #1;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      set_op(6'h00, 6'h20, 5'd0, 16'h0, 32'd77, 32'd0);
      tick(fi, fo, fs);
      in_valid = 1'b0;
      #1;
      chk("post_flush_valid", 32'(out_valid), 32'd1);
      chk("post_flush_first", alu_first, 32'd77);
      tick(fi, fo, fs);
      #1;
      chk("post_flush_alone", 32'(out_valid), 32'd0);

      // Reset during a stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_op(6'h00, 6'h20, 5'd0, 16'h0, 32'd88, 32'd0);
      tick(fi, fo, fs);
      in_valid = 1'b0;
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      tick(fi, fo, fs);
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_first", alu_first, 32'd0);
      rst_n = 1'b1;
      tick(fi, fo, fs);
      #1;
      chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rel_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
